cpu_run_ctrl: RTL and testbench

- Sequencer that owns the external memory ports and the enable input of the 5-stage RV64 core.
- Runs one session per start pulse:
  - streams a program into instruction memory;
  - runs the core for a programmed number of cycles;
  - reads back a window of data memory as a valid/ready stream.
- Sits between the testbench/host and the cpu top level; cpu reset stays with arst_n.

---
 rtl/cpu_run_ctrl_pkg.sv | 41 ++++
 rtl/stream_down_counter.sv | 54 +++++
 rtl/cpu_run_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types and constants for the cpu run controller: session state
// encoding, byte-address shifts for the two memories and default widths.
package cpu_ctrl_pkg;

    localparam int DEF_IW_W   = 7;
    localparam int DEF_DW_W   = 7;
    localparam int DEF_CYC_W  = 32;
    localparam int DEF_RD_LAT = 1;

    // Word index to byte address: imem holds 32-bit words, dmem 64-bit words.
    localparam int IMEM_SHIFT = 2;
    localparam int DMEM_SHIFT = 3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_RUN       = 3'd2,
        ST_DUMP_REQ  = 3'd3,
        ST_DUMP_WAIT = 3'd4,
        ST_DUMP_OUT  = 3'd5,
        ST_DONE      = 3'd6
    } state_e;

    // Phases run in the order LOAD, RUN, DUMP; empty phases are skipped.
    function automatic state_e first_phase(input logic load_nz,
                                           input logic run_nz,
                                           input logic dump_nz);
        state_e nxt;
        if (load_nz) begin
            nxt = ST_LOAD;
        end else if (run_nz) begin
            nxt = ST_RUN;
        end else if (dump_nz) begin
            nxt = ST_DUMP_REQ;
        end else begin
            nxt = ST_DONE;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/stream_down_counter.sv
// Loadable stream counter: counts the remaining items down while counting
// the item index up. last_o marks the final item so the owner can leave
// its phase on the same edge that consumes it. Steps stop at zero remaining.
module stream_down_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] len_i,
    input  logic         step_i,
    output logic [W-1:0] idx_o,
    output logic         last_o
);

    localparam logic [W-1:0] ONE  = W'(1);
    localparam logic [W-1:0] ZERO = {W{1'b0}};

    logic [W-1:0] rem_q;
    logic [W-1:0] rem_d;
    logic [W-1:0] idx_q;
    logic [W-1:0] idx_d;

    // Next count: a fresh load wins over a step; exhausted counters hold.
    always_comb begin
        rem_d = rem_q;
        idx_d = idx_q;
        if (load_i) begin
            rem_d = len_i;
            idx_d = ZERO;
        end else if (step_i && (rem_q != ZERO)) begin
            rem_d = rem_q - ONE;
            idx_d = idx_q + ONE;
        end else begin
            rem_d = rem_q;
            idx_d = idx_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= ZERO;
            idx_q <= ZERO;
        end else begin
            rem_q <= rem_d;
            idx_q <= idx_d;
        end
    end

    assign idx_o  = idx_q;
    assign last_o = (rem_q == ONE);

endmodule

// File: rtl/cpu_run_ctrl.sv
// Session sequencer for the RV64 core: streams a program into imem, runs
// the core for a set number of cycles, then streams a window of dmem out.
// The core itself keeps its own reset; this block only gates its enable.
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int IW_W   = DEF_IW_W,
    parameter int DW_W   = DEF_DW_W,
    parameter int CYC_W  = DEF_CYC_W,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             start,
    input  logic [IW_W:0]    prog_len,
    input  logic [CYC_W-1:0] run_cycles,
    input  logic [DW_W:0]    dump_len,
    input  logic             load_valid,
    input  logic [31:0]      load_data,
    output logic             load_ready,
    output logic             dump_valid,
    output logic [63:0]      dump_data,
    input  logic             dump_ready,
    output logic             busy,
    output logic             done,
    output logic             cpu_enable,
    output logic [63:0]      addr_ext,
    output logic             wen_ext,
    output logic             ren_ext,
    output logic [31:0]      wdata_ext,
    output logic [63:0]      addr_ext_2,
    output logic             wen_ext_2,
    output logic             ren_ext_2,
    output logic [63:0]      wdata_ext_2,
    input  logic [63:0]      rdata_ext_2,
    output logic [CYC_W-1:0] cycle_cnt
);

    // Memory capacities in words; longer requests are clamped to these.
    localparam logic [IW_W:0] IMEM_WORDS = {1'b1, {IW_W{1'b0}}};
    localparam logic [DW_W:0] DMEM_WORDS = {1'b1, {DW_W{1'b0}}};
    localparam logic [1:0]    WAIT_LAST  = 2'(RD_LAT - 1);

    state_e          state_q;
    state_e          state_d;
    logic            cpu_enable_q;
    logic [63:0]     dump_data_q;
    logic [1:0]      wait_q;
    logic            run_nz_q;
    logic            dump_nz_q;

    logic            start_acc_s;
    logic [IW_W:0]   prog_sat_s;
    logic [DW_W:0]   dump_sat_s;
    logic            load_hs_s;
    logic            run_step_s;
    logic            dump_hs_s;
    logic [IW_W:0]   ld_idx_s;
    logic            ld_last_s;
    logic [DW_W:0]   dp_idx_s;
    logic            dp_last_s;
    logic            run_last_s;

    assign start_acc_s = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign prog_sat_s  = (prog_len > IMEM_WORDS) ? IMEM_WORDS : prog_len;
    assign dump_sat_s  = (dump_len > DMEM_WORDS) ? DMEM_WORDS : dump_len;
    assign load_hs_s   = (state_q == ST_LOAD) && load_valid;
    assign run_step_s  = (state_q == ST_RUN);
    assign dump_hs_s   = (state_q == ST_DUMP_OUT) && dump_ready;

    stream_down_counter #(.W(IW_W + 1)) u_load_cnt (
        .clk    (clk),
        .rst_n  (arst_n),
        .load_i (start_acc_s),
        .len_i  (prog_sat_s),
        .step_i (load_hs_s),
        .idx_o  (ld_idx_s),
        .last_o (ld_last_s)
    );

    // The run counter's up-index doubles as the visible cycle count, so it
    // clears on start and holds its final value until the next session.
    stream_down_counter #(.W(CYC_W)) u_run_cnt (
        .clk    (clk),
        .rst_n  (arst_n),
        .load_i (start_acc_s),
        .len_i  (run_cycles),
        .step_i (run_step_s),
        .idx_o  (cycle_cnt),
        .last_o (run_last_s)
    );

    stream_down_counter #(.W(DW_W + 1)) u_dump_cnt (
        .clk    (clk),
        .rst_n  (arst_n),
        .load_i (start_acc_s),
        .len_i  (dump_sat_s),
        .step_i (dump_hs_s),
        .idx_o  (dp_idx_s),
        .last_o (dp_last_s)
    );

    // Next-state selection for the session sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = first_phase(prog_sat_s != {(IW_W + 1){1'b0}},
                                          run_cycles != {CYC_W{1'b0}},
                                          dump_sat_s != {(DW_W + 1){1'b0}});
                end else begin
                    state_d = state_q;
                end
            end
            ST_LOAD: begin
                if (load_hs_s && ld_last_s) begin
                    state_d = first_phase(1'b0, run_nz_q, dump_nz_q);
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (run_last_s) begin
                    state_d = first_phase(1'b0, 1'b0, dump_nz_q);
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DUMP_REQ: begin
                state_d = ST_DUMP_WAIT;
            end
            ST_DUMP_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = ST_DUMP_OUT;
                end else begin
                    state_d = ST_DUMP_WAIT;
                end
            end
            ST_DUMP_OUT: begin
                if (dump_hs_s) begin
                    state_d = dp_last_s ? ST_DONE : ST_DUMP_REQ;
                end else begin
                    state_d = ST_DUMP_OUT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, core enable, read-latency wait and readback capture registers.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= ST_IDLE;
            cpu_enable_q <= 1'b0;
            dump_data_q  <= 64'd0;
            wait_q       <= 2'd0;
            run_nz_q     <= 1'b0;
            dump_nz_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cpu_enable_q <= (state_d == ST_RUN);
            if (start_acc_s) begin
                run_nz_q  <= (run_cycles != {CYC_W{1'b0}});
                dump_nz_q <= (dump_sat_s != {(DW_W + 1){1'b0}});
            end
            if (state_q == ST_DUMP_WAIT) begin
                if (wait_q == WAIT_LAST) begin
                    dump_data_q <= rdata_ext_2;
                    wait_q      <= 2'd0;
                end else begin
                    wait_q <= wait_q + 2'd1;
                end
            end else begin
                wait_q <= 2'd0;
            end
        end
    end

    // Memory port drive: imem writes follow the load handshake in the same
    // cycle; dmem is read with a single-cycle request pulse per word.
    always_comb begin
        load_ready = 1'b0;
        wen_ext    = 1'b0;
        addr_ext   = 64'd0;
        wdata_ext  = 32'd0;
        ren_ext_2  = 1'b0;
        addr_ext_2 = 64'd0;
        case (state_q)
            ST_LOAD: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    wen_ext   = 1'b1;
                    addr_ext  = 64'(ld_idx_s) << IMEM_SHIFT;
                    wdata_ext = load_data;
                end else begin
                    wen_ext   = 1'b0;
                    addr_ext  = 64'd0;
                    wdata_ext = 32'd0;
                end
            end
            ST_DUMP_REQ: begin
                ren_ext_2  = 1'b1;
                addr_ext_2 = 64'(dp_idx_s) << DMEM_SHIFT;
            end
            default: begin
                load_ready = 1'b0;
            end
        endcase
    end

    assign busy        = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done        = (state_q == ST_DONE);
    assign dump_valid  = (state_q == ST_DUMP_OUT);
    assign dump_data   = dump_data_q;
    assign cpu_enable  = cpu_enable_q;
    assign ren_ext     = 1'b0;
    assign wen_ext_2   = 1'b0;
    assign wdata_ext_2 = 64'd0;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: table of sessions plus random sessions, checked
// against counts and contents derived from the session lengths, and a
// hand-written reset-during-run sequence.
module tb_cpu_run_ctrl;

    localparam int IW_W   = 7;
    localparam int DW_W   = 7;
    localparam int CYC_W  = 32;
    localparam int RD_LAT = 1;

    logic             clk;
    logic             arst_n;
    logic             start;
    logic [IW_W:0]    prog_len;
    logic [CYC_W-1:0] run_cycles;
    logic [DW_W:0]    dump_len;
    logic             load_valid;
    logic [31:0]      load_data;
    logic             load_ready;
    logic             dump_valid;
    logic [63:0]      dump_data;
    logic             dump_ready;
    logic             busy;
    logic             done;
    logic             cpu_enable;
    logic [63:0]      addr_ext;
    logic             wen_ext;
    logic             ren_ext;
    logic [31:0]      wdata_ext;
    logic [63:0]      addr_ext_2;
    logic             wen_ext_2;
    logic             ren_ext_2;
    logic [63:0]      wdata_ext_2;
    logic [63:0]      rdata_ext_2;
    logic [CYC_W-1:0] cycle_cnt;

    cpu_run_ctrl #(.IW_W(IW_W), .DW_W(DW_W), .CYC_W(CYC_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .arst_n(arst_n), .start(start), .prog_len(prog_len),
        .run_cycles(run_cycles), .dump_len(dump_len), .load_valid(load_valid),
        .load_data(load_data), .load_ready(load_ready), .dump_valid(dump_valid),
        .dump_data(dump_data), .dump_ready(dump_ready), .busy(busy), .done(done),
        .cpu_enable(cpu_enable), .addr_ext(addr_ext), .wen_ext(wen_ext),
        .ren_ext(ren_ext), .wdata_ext(wdata_ext), .addr_ext_2(addr_ext_2),
        .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2), .wdata_ext_2(wdata_ext_2),
        .rdata_ext_2(rdata_ext_2), .cycle_cnt(cycle_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: imem captures writes, dmem answers reads one cycle later.
    logic [31:0] imem [0:127];
    logic [63:0] dmem [0:127];
    logic [63:0] rdata_q;
    always @(posedge clk) begin
        if (wen_ext) imem[addr_ext[8:2]] <= wdata_ext;
        if (ren_ext_2) rdata_q <= dmem[addr_ext_2[9:3]];
    end
    assign rdata_ext_2 = rdata_q;

    typedef struct {
        int pl; int rc; int dl; int vmode; int rmode; int restart;
        int exp_n; int exp_cyc; int exp_d;
    } vec_t;

    int          tests;
    int          fails;
    int          cyc;
    int          wr_cnt, en_cnt, ren_cnt, busy_cnt, exp_n_m;
    int          first_wr, last_wr, first_en, last_en, last_ren;
    bit          gap_chk, stall_prev, mon_hs, mon_stall;
    logic [63:0] held;
    logic [63:0] got [$];
    logic [31:0] words [0:255];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon_clear();
        wr_cnt = 0; en_cnt = 0; ren_cnt = 0; busy_cnt = 0; exp_n_m = 0;
        first_wr = 0; last_wr = 0; first_en = 0; last_en = 0; last_ren = 0;
        stall_prev = 1'b0; mon_hs = 1'b0; mon_stall = 1'b0; held = 64'd0;
        got.delete();
    endtask

    // Per-cycle observation at the falling edge.
    task automatic monitor();
        if (wen_ext) begin
            chk("wen_needs_valid", 64'(load_valid), 64'd1);
            chk("wr_in_range", 64'(wr_cnt < exp_n_m), 64'd1);
            chk("wr_addr", addr_ext, 64'(wr_cnt) * 64'd4);
            chk("wr_data", 64'(wdata_ext), 64'(words[wr_cnt & 255]));
            if (wr_cnt == 0) first_wr = cyc;
            last_wr = cyc;
            wr_cnt++;
        end
        if (cpu_enable) begin
            if (en_cnt == 0) begin
                first_en = cyc;
                chk("run_after_load", 64'(wr_cnt), 64'(exp_n_m));
            end
            last_en = cyc;
            en_cnt++;
        end
        if (ren_ext_2) begin
            chk("rd_addr", addr_ext_2, 64'(ren_cnt) * 64'd8);
            chk("rd_while_pending", 64'(dump_valid), 64'd0);
            if (gap_chk && ren_cnt > 0) chk("rd_gap", 64'(cyc - last_ren), 64'(2 + RD_LAT));
            last_ren = cyc;
            ren_cnt++;
        end
        if (stall_prev) begin
            chk("stall_valid", 64'(dump_valid), 64'd1);
            chk("stall_data", dump_data, held);
        end
        mon_hs    = dump_valid && dump_ready;
        mon_stall = dump_valid && !dump_ready;
        if (mon_hs) got.push_back(dump_data);
        if (mon_stall) held = dump_data;
        stall_prev = mon_stall;
        if (busy) busy_cnt++;
        cyc++;
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_en"}, 64'(cpu_enable), 64'd0);
        chk({tag, "_cnt"}, 64'(cycle_cnt), 64'd0);
        chk({tag, "_ldrdy"}, 64'(load_ready), 64'd0);
        chk({tag, "_dvalid"}, 64'(dump_valid), 64'd0);
        chk({tag, "_ddata"}, dump_data, 64'd0);
        chk({tag, "_ren2"}, 64'(ren_ext_2), 64'd0);
        chk({tag, "_addr2"}, addr_ext_2, 64'd0);
    endtask

    task automatic run_session(input vec_t v, input bit fixed_words);
        int  hold;
        int  k;
        int  start_cyc;
        bit  all0;
        for (int i = 0; i < 256; i++) begin
            if (!fixed_words || i >= 4) words[i] = $urandom;
        end
        mon_clear();
        exp_n_m = v.exp_n;
        gap_chk = (v.rmode == 0);
        all0 = (v.exp_n == 0) && (v.exp_cyc == 0) && (v.exp_d == 0);
        prog_len   = (IW_W + 1)'(v.pl);
        run_cycles = CYC_W'(v.rc);
        dump_len   = (DW_W + 1)'(v.dl);
        load_valid = 1'b0;
        dump_ready = 1'b0;
        start      = 1'b1;
        start_cyc  = cyc;
        cycle();
        start = 1'b0;
        chk("cnt_cleared", 64'(cycle_cnt), 64'd0);
        chk("done_after_start", 64'(done), 64'(all0));
        chk("busy_after_start", 64'(busy), 64'(!all0));
        hold = 0;
        k = 0;
        while (!done && k < 5000) begin
            if (v.restart != 0 && k < 3) begin
                load_valid = 1'b0;
                start = (k == 1);
                if (k == 1) begin
                    prog_len = 8'd1; run_cycles = 32'd50; dump_len = 8'd0;
                end
            end else begin
                start = 1'b0;
                case (v.vmode)
                    0: load_valid = 1'b1;
                    1: load_valid = (k % 2 == 0);
                    default: load_valid = 1'($urandom_range(0, 1));
                endcase
            end
            load_data = words[wr_cnt & 255];
            case (v.rmode)
                0: dump_ready = 1'b1;
                1: dump_ready = (hold >= 5);
                default: dump_ready = 1'($urandom_range(0, 1));
            endcase
            cycle();
            if (mon_hs) hold = 0;
            else if (mon_stall) hold++;
            k++;
        end
        start = 1'b0;
        chk("done_timeout", 64'(done), 64'd1);
        chk("busy_end", 64'(busy), 64'd0);
        chk("en_end", 64'(cpu_enable), 64'd0);
        chk("wr_count", 64'(wr_cnt), 64'(v.exp_n));
        chk("en_count", 64'(en_cnt), 64'(v.exp_cyc));
        chk("cycle_cnt", 64'(cycle_cnt), 64'(v.exp_cyc));
        chk("rd_count", 64'(ren_cnt), 64'(v.exp_d));
        chk("dump_count", 64'(got.size()), 64'(v.exp_d));
        for (int i = 0; i < v.exp_d && i < got.size(); i++) chk("dump_word", got[i], dmem[i]);
        for (int i = 0; i < v.exp_n; i++) chk("imem_word", 64'(imem[i]), 64'(words[i]));
        chk("ren_tied", 64'(ren_ext), 64'd0);
        chk("wen2_tied", 64'(wen_ext_2), 64'd0);
        chk("wdata2_tied", wdata_ext_2, 64'd0);
        if (v.exp_cyc > 0) chk("run_contiguous", 64'(last_en - first_en), 64'(v.exp_cyc - 1));
        if (v.vmode == 0 && v.restart == 0 && v.exp_n > 0) begin
            chk("load_first", 64'(first_wr), 64'(start_cyc + 1));
            chk("load_burst", 64'(last_wr - first_wr), 64'(v.exp_n - 1));
            if (v.exp_cyc > 0) chk("run_follows_load", 64'(first_en), 64'(last_wr + 1));
        end
        if (all0) chk("busy_never", 64'(busy_cnt), 64'd0);
    endtask

    initial begin
        vec_t tbl [8];
        vec_t rv;
        tests = 0; fails = 0; cyc = 0;
        mon_clear();
        gap_chk = 1'b0;
        arst_n = 1'b0; start = 1'b0; prog_len = '0; run_cycles = '0; dump_len = '0;
        load_valid = 1'b0; load_data = 32'd0; dump_ready = 1'b0;

        dmem[0] = 64'h0000_0000_0000_000F;
        for (int i = 1; i < 128; i++) dmem[i] = {32'hDA7A_0000 | 32'(i), $urandom};
        words[0] = 32'h0050_0093; words[1] = 32'h00A0_0113;
        words[2] = 32'h0020_81B3; words[3] = 32'h0030_3023;

        //            pl   rc  dl vm rm rs  n   cyc  d
        tbl[0] = '{   4,  12,   2, 0, 0, 0,   4, 12,   2};
        tbl[1] = '{   5,   3,   3, 1, 1, 0,   5,  3,   3};
        tbl[2] = '{   0,   0,   0, 0, 0, 0,   0,  0,   0};
        tbl[3] = '{ 200,   2,   1, 0, 0, 0, 128,  2,   1};
        tbl[4] = '{   0,   1, 255, 0, 0, 0,   0,  1, 128};
        tbl[5] = '{   6,   7,   1, 0, 0, 1,   6,  7,   1};
        tbl[6] = '{   3,   0,   0, 2, 2, 0,   3,  0,   0};
        tbl[7] = '{   0,   0,   4, 0, 2, 0,   0,  0,   4};

        #3;
        chk_all_zero("reset");
        @(posedge clk); #1;
        @(posedge clk); #1;
        arst_n = 1'b1;
        @(posedge clk); #1;

        for (int t = 0; t < 8; t++) run_session(tbl[t], t == 0);

        for (int r = 0; r < 12; r++) begin
            rv.pl = ($urandom_range(0, 6) == 0) ? int'($urandom_range(129, 255)) : int'($urandom_range(0, 10));
            rv.dl = ($urandom_range(0, 6) == 0) ? int'($urandom_range(129, 255)) : int'($urandom_range(0, 5));
            rv.rc = int'($urandom_range(0, 25));
            rv.vmode = int'($urandom_range(0, 2));
            rv.rmode = int'($urandom_range(0, 2));
            rv.restart = 0;
            rv.exp_n = (rv.pl > 128) ? 128 : rv.pl;
            rv.exp_cyc = rv.rc;
            rv.exp_d = (rv.dl > 128) ? 128 : rv.dl;
            run_session(rv, 1'b0);
        end

        // Reset in the middle of a long run.
        mon_clear();
        prog_len = 8'd0; run_cycles = 32'd100; dump_len = 8'd0; start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (40) cycle();
        chk("mid_run_cnt", 64'(cycle_cnt), 64'd40);
        chk("mid_run_en", 64'(cpu_enable), 64'd1);
        arst_n = 1'b0;
        #2;
        chk_all_zero("abort");
        @(posedge clk); #1;
        arst_n = 1'b1;
        mon_clear();
        repeat (20) cycle();
        chk("no_reenable", 64'(en_cnt), 64'd0);
        chk("idle_not_busy", 64'(busy_cnt), 64'd0);
        chk("idle_not_done", 64'(done), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
